// File: rtl/decoder3x8_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshakes, a sweep mode
// that emits all eight one-hot words in order, and an output-handshake counter.
module decoder3x8_seq #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         A,
  input  logic               sweep_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         Y,
  output logic               busy,
  output logic               sweep_done,
  output logic [COUNT_W-1:0] count
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] sweep_idx;
  logic       slot_free;
  logic       in_hs;
  logic       out_hs;

  // rst_n gates in_ready so nothing is offered to the producer while held in reset
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rst_n && (state == IDLE) && slot_free && !sweep_start;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign busy      = (state == SWEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sweep_idx  <= 3'd0;
      out_valid  <= 1'b0;
      Y          <= 8'h00;
      sweep_done <= 1'b0;
      count      <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (out_hs) begin
        count <= count + COUNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          // A sweep request beats a pending input, which is why in_ready masks sweep_start
          if (slot_free && sweep_start) begin
            state     <= SWEEP;
            sweep_idx <= 3'd0;
            Y         <= 8'h01;
            out_valid <= 1'b1;
          end else if (in_hs) begin
            Y         <= 8'b1 << A;
            out_valid <= 1'b1;
          end else if (out_hs) begin
            Y         <= 8'h00;
            out_valid <= 1'b0;
          end
        end
        SWEEP: begin
          if (out_hs) begin
            if (sweep_idx == 3'd7) begin
              state      <= IDLE;
              sweep_idx  <= 3'd0;
              Y          <= 8'h00;
              out_valid  <= 1'b0;
              sweep_done <= 1'b1;
            end else begin
              sweep_idx <= sweep_idx + 3'd1;
              Y         <= 8'b1 << (sweep_idx + 3'd1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder3x8_seq.sv
// Directed self-checking bench for decoder3x8_seq: each task drives one scenario
// and compares outputs against hand-computed values one step after the clock edge.
module tb_decoder3x8_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] A;
  logic       sweep_start;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic       busy;
  logic       sweep_done;
  logic [7:0] count;

  int vectors;
  int miscompares;
  logic [7:0] exp_count;

  decoder3x8_seq #(.COUNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .sweep_start(sweep_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Y          (Y),
    .busy       (busy),
    .sweep_done (sweep_done),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1ns past the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; A = 3'd0; sweep_start = 1'b0; out_ready = 1'b0;
    exp_count = 8'd0;
    step(); step();
    vectors++;
    if (out_valid !== 1'b0 || Y !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_out: out_valid=%b Y=%h, required 0 00", out_valid, Y);
    end
    vectors++;
    if (busy !== 1'b0 || sweep_done !== 1'b0 || count !== 8'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl: busy=%b done=%b count=%0d in_ready=%b, required 0 0 0 0",
               busy, sweep_done, count, in_ready);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    A = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (Y !== 8'h01 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_decode: Y=%h out_valid=%b, required 01 1", Y, out_valid);
    end
    step();
    exp_count = exp_count + 8'd1;
    vectors++;
    if (Y !== 8'h00 || out_valid !== 1'b0 || count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL basic_drain: Y=%h out_valid=%b count=%0d, required 00 0 %0d",
               Y, out_valid, count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    A = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
    step();
    A = 3'd2;
    for (int i = 0; i < 3; i++) begin
      sweep_start = (i == 1);
      #1;
      vectors++;
      if (Y !== 8'h20 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: Y=%h out_valid=%b in_ready=%b busy=%b, required 20 1 0 0",
                 i, Y, out_valid, in_ready, busy);
      end
      step();
    end
    sweep_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (Y !== 8'h20 || count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL bp_stalled_final: Y=%h count=%0d, required 20 %0d", Y, count, exp_count);
    end
    step();
    exp_count = exp_count + 8'd1;
    vectors++;
    if (Y !== 8'h00 || out_valid !== 1'b0 || count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL bp_release: Y=%h out_valid=%b count=%0d, required 00 0 %0d",
               Y, out_valid, count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] codes [3];
    logic [7:0] words [3];
    codes = '{3'd3, 3'd6, 3'd7};
    words = '{8'h08, 8'h40, 8'h80};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = codes[i];
      step();
      vectors++;
      if (Y !== words[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_word[%0d]: Y=%h out_valid=%b, required %h 1", i, Y, out_valid, words[i]);
      end
    end
    in_valid = 1'b0;
    step();
    exp_count = exp_count + 8'd3;
    vectors++;
    if (Y !== 8'h00 || out_valid !== 1'b0 || count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain: Y=%h out_valid=%b count=%0d, required 00 0 %0d",
               Y, out_valid, count, exp_count);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] expected;
    in_valid = 1'b1; A = 3'd1; out_ready = 1'b1; sweep_start = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sweep_collision_ready: in_ready=%b, required 0", in_ready);
    end
    step();
    sweep_start = 1'b0;
    expected = 8'h01;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (Y !== expected || out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || sweep_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL sweep_word[%0d]: Y=%h ov=%b busy=%b in_ready=%b done=%b, required %h 1 1 0 0",
                 i, Y, out_valid, busy, in_ready, sweep_done, expected);
      end
      expected = expected << 1;
      step();
    end
    in_valid = 1'b0;
    exp_count = exp_count + 8'd8;
    vectors++;
    if (sweep_done !== 1'b1 || busy !== 1'b0 || Y !== 8'h00 || out_valid !== 1'b0 || count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL sweep_end: done=%b busy=%b Y=%h ov=%b count=%0d, required 1 0 00 0 %0d",
               sweep_done, busy, Y, out_valid, count, exp_count);
    end
    step();
    vectors++;
    if (sweep_done !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sweep_done_pulse: done=%b ov=%b, required 0 0", sweep_done, out_valid);
    end
  endtask

  task automatic test_stall_and_reset();
    sweep_start = 1'b1; in_valid = 1'b1; A = 3'd4; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL collision_ready: in_ready=%b, required 0", in_ready);
    end
    step();
    sweep_start = 1'b0;
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sweep_start = (i == 1);
      #1;
      vectors++;
      if (Y !== 8'h04 || busy !== 1'b1 || out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: Y=%h busy=%b ov=%b, required 04 1 1", i, Y, busy, out_valid);
      end
      step();
    end
    sweep_start = 1'b0; out_ready = 1'b1;
    step();
    exp_count = exp_count + 8'd3;
    vectors++;
    if (Y !== 8'h08 || count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL stall_resume: Y=%h count=%0d, required 08 %0d", Y, count, exp_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (Y !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: Y=%h ov=%b busy=%b count=%0d, required 00 0 0 0",
               Y, out_valid, busy, count);
    end
    in_valid = 1'b0;
    step(); step();
    vectors++;
    if (sweep_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_abort: done=%b busy=%b, required 0 0", sweep_done, busy);
    end
    rst_n = 1'b1;
    exp_count = 8'd0;
    step();
    vectors++;
    if (sweep_done !== 1'b0 || count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL reset_after: done=%b count=%0d, required 0 0", sweep_done, count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] expected;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      A = 3'(i % 8);
      step();
      expected = 8'b1 << (i % 8);
      if ((i % 64) == 5) begin
        vectors++;
        if (Y !== expected) begin
          miscompares++;
          $display("[TB] FAIL wrap_word[%0d]: Y=%h, required %h", i, Y, expected);
        end
      end
    end
    vectors++;
    if (count !== 8'd255) begin
      miscompares++;
      $display("[TB] FAIL wrap_255: count=%0d, required 255", count);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (count !== 8'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrap_zero: count=%0d ov=%b, required 0 0", count, out_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_sweep();
    test_stall_and_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
